// File: rtl/scan_window_counter_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and constants for the window-gated scan hit counter.
//   scan_state_t : window FSM states
//   DEF_*        : default channel count, count width and window-length width
//   sel_w(n)     : width of a channel-select index for n channels (at least 1)
// -----------------------------------------------------------------------------
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_COUNT = 2'd2,
    ST_LATCH = 2'd3
  } scan_state_t;

  localparam int DEF_NCH = 8;
  localparam int DEF_CW  = 32;
  localparam int DEF_TW  = 32;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_window_counter_if.sv
// -----------------------------------------------------------------------------
// scan_window_counter_if
// Control, hit and readout signals of the scan window counter.
//   start, abort, window_len : window control from the scan controller
//   hit[NCH]                 : per-channel count enables
//   busy, done               : window status (done is a one-cycle pulse)
//   rd_sel, rd_data, rd_ovf  : registered shadow-bank readout by channel
// master = scan controller side, slave = counter side.
// -----------------------------------------------------------------------------
interface scan_window_counter_if #(
  parameter int NCH = scan_pkg::DEF_NCH,
  parameter int CW  = scan_pkg::DEF_CW,
  parameter int TW  = scan_pkg::DEF_TW
);
  localparam int SW = scan_pkg::sel_w(NCH);

  logic           start;
  logic           abort;
  logic [TW-1:0]  window_len;
  logic [NCH-1:0] hit;
  logic           busy;
  logic           done;
  logic [SW-1:0]  rd_sel;
  logic [CW-1:0]  rd_data;
  logic           rd_ovf;

  modport master (
    output start, abort, window_len, hit, rd_sel,
    input  busy, done, rd_data, rd_ovf
  );

  modport slave (
    input  start, abort, window_len, hit, rd_sel,
    output busy, done, rd_data, rd_ovf
  );

endinterface

// File: rtl/scan_window_counter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating W-bit event counter with a sticky overflow flag.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of count and flag (wins over en)
//   en       : count this cycle
//   cnt      : current count
//   ovf      : set when an increment is requested while already at max
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  logic [W-1:0] cnt_d, cnt_q;
  logic         ovf_d, ovf_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      if (&cnt_q) ovf_d = 1'b1;          // hold at max, never wrap
      else        cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/scan_window_counter.sv
// -----------------------------------------------------------------------------
// scan_window_counter
// Multi-channel window-gated hit counter. start clears the live counters,
// counts hit cycles for window_len cycles, then copies the live bank into a
// shadow bank that stays readable while the next window runs.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : scan_window_counter_if.slave (control, hits, status, readout)
// -----------------------------------------------------------------------------
module scan_window_counter
  import scan_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = DEF_CW,
  parameter int TW  = DEF_TW
) (
  input  logic                    clk,
  input  logic                    rst,
  scan_window_counter_if.slave    bus
);

  localparam int SW = sel_w(NCH);

  scan_state_t    state_d, state_q;
  logic [TW-1:0]  timer_d, timer_q;
  logic           busy_d, busy_q;
  logic           done_d, done_q;
  logic           clr_live, count_en;

  logic [CW-1:0]  live_cnt     [NCH];
  logic [NCH-1:0] live_ovf;
  logic [CW-1:0]  shadow_cnt_d [NCH];
  logic [CW-1:0]  shadow_cnt_q [NCH];
  logic [NCH-1:0] shadow_ovf_d, shadow_ovf_q;

  logic [CW-1:0]  rd_data_d, rd_data_q;
  logic           rd_ovf_d, rd_ovf_q;

  // ---------------------------------------------------------------------------
  // Window FSM and timer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        // abort is meaningless here, so start always wins
        if (bus.start) begin
          state_d = ST_CLEAR;
          timer_d = bus.window_len;
        end
      end
      ST_CLEAR: begin
        if (bus.abort)            state_d = ST_IDLE;
        else if (timer_q == '0)   state_d = ST_LATCH;
        else                      state_d = ST_COUNT;
      end
      ST_COUNT: begin
        timer_d = timer_q - TW'(1);
        // abort beats expiry; timer==1 marks the final counted cycle
        if (bus.abort)                 state_d = ST_IDLE;
        else if (timer_q == TW'(1))    state_d = ST_LATCH;
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status is registered: busy follows the next state, done marks the
    // cycle right after LATCH, when the shadow bank has just been written.
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_q == ST_LATCH);
    clr_live = (state_q == ST_CLEAR);
    count_en = (state_q == ST_COUNT);
  end

  // ---------------------------------------------------------------------------
  // Live counters
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sat_counter #(.W(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_live),
      .en  (count_en & bus.hit[i]),
      .cnt (live_cnt[i]),
      .ovf (live_ovf[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Shadow bank and read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_ovf_d = shadow_ovf_q;
    for (int i = 0; i < NCH; i++) shadow_cnt_d[i] = shadow_cnt_q[i];
    if (state_q == ST_LATCH) begin
      shadow_ovf_d = live_ovf;
      for (int i = 0; i < NCH; i++) shadow_cnt_d[i] = live_cnt[i];
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    // Selects beyond the last channel read as zero.
    if ({1'b0, bus.rd_sel} < (SW+1)'(NCH)) begin
      rd_data_d = shadow_cnt_q[bus.rd_sel];
      rd_ovf_d  = shadow_ovf_q[bus.rd_sel];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_data_q    <= '0;
      rd_ovf_q     <= 1'b0;
      shadow_ovf_q <= '0;
      // NOTE: the shadow bank is software-visible and must read back as zero
      // after reset, so this storage array is reset like ordinary flops.
      for (int i = 0; i < NCH; i++) shadow_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_data_q    <= rd_data_d;
      rd_ovf_q     <= rd_ovf_d;
      shadow_ovf_q <= shadow_ovf_d;
      for (int i = 0; i < NCH; i++) shadow_cnt_q[i] <= shadow_cnt_d[i];
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_ovf  = rd_ovf_q;

endmodule
